// File: rtl/rc4_key_scheduler.sv
// -----------------------------------------------------------------------------
// rc4_key_scheduler
//   Hands out candidate RC4 keys (0 .. 2^KEY_BITS-1, in order) to a pool of
//   NUM_CORES decrypt cores. Round-robin dispatch, one per cycle. Each
//   completion from a busy core is counted. The search stops either on the
//   first valid result (SOLVED) or once every key has been tried (EXHAUSTED).
//
// Ports
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   start        one-cycle pulse: begin a search from key 0
//   core_done    per-core completion pulse
//   core_valid   per-core result, meaningful only with core_done
//   core_start   per-core dispatch pulse (registered)
//   core_key     per-core key, slice i held from dispatch to next dispatch
//   core_abort   forces all cores idle (solve entry / restart)
//   busy         search in progress (RUN or DRAIN)
//   solved       valid key found, sticky until next start
//   exhausted    key space tried with no hit, sticky until next start
//   found_key    winning key
//   found_core   index of the winning core
//   keys_done    number of completed keys
// -----------------------------------------------------------------------------
module rc4_key_scheduler #(
    parameter int NUM_CORES = 4,
    parameter int KEY_BITS  = 22
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic [NUM_CORES-1:0]          core_done,
    input  logic [NUM_CORES-1:0]          core_valid,
    output logic [NUM_CORES-1:0]          core_start,
    output logic [NUM_CORES*KEY_BITS-1:0] core_key,
    output logic                          core_abort,
    output logic                          busy,
    output logic                          solved,
    output logic                          exhausted,
    output logic [KEY_BITS-1:0]           found_key,
    output logic [2:0]                    found_core,
    output logic [KEY_BITS:0]             keys_done
);

    localparam int IDXW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [KEY_BITS-1:0] LAST_KEY = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_SOLVED,
        S_EXHAUSTED
    } state_t;

    state_t                        r_state;
    state_t                        w_next_state;

    logic [NUM_CORES-1:0]          r_busy_core;
    logic [IDXW-1:0]               r_last;
    logic [KEY_BITS-1:0]           r_next_key;
    logic [NUM_CORES-1:0]          r_core_start;
    logic [NUM_CORES*KEY_BITS-1:0] r_core_key;
    logic                          r_abort_pulse;
    logic [KEY_BITS-1:0]           r_found_key;
    logic [2:0]                    r_found_core;
    logic [KEY_BITS:0]             r_keys_done;

    logic                          w_restart;
    logic                          w_active;
    logic [NUM_CORES-1:0]          w_done_ok;
    logic [NUM_CORES-1:0]          w_hits;
    logic                          w_hit;
    logic [IDXW-1:0]               w_hit_idx;
    logic [KEY_BITS:0]             w_done_cnt;
    logic                          w_pick_ok;
    logic [IDXW-1:0]               w_pick;
    logic [IDXW:0]                 w_cand;
    logic                          w_dispatch;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    always_comb begin
        w_restart  = start && ((r_state == S_IDLE) || (r_state == S_SOLVED) ||
                               (r_state == S_EXHAUSTED));
        w_active   = (r_state == S_RUN) || (r_state == S_DRAIN);
        // completions only count from cores we believe are working
        w_done_ok  = w_active ? (core_done & r_busy_core) : '0;
        w_hits     = w_done_ok & core_valid;
        w_hit      = |w_hits;

        // descending scan so the lowest index is the last one written
        w_hit_idx  = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (w_hits[i]) w_hit_idx = IDXW'(i);
        end

        w_done_cnt = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            w_done_cnt = w_done_cnt + (KEY_BITS+1)'(w_done_ok[i]);
        end

        // round-robin: first idle core after the last one dispatched,
        // judged on registered idle flags only
        w_pick_ok = 1'b0;
        w_pick    = '0;
        w_cand    = '0;
        for (int k = 1; k <= NUM_CORES; k++) begin
            w_cand = {1'b0, r_last} + (IDXW+1)'(k);
            if (w_cand >= (IDXW+1)'(NUM_CORES)) w_cand = w_cand - (IDXW+1)'(NUM_CORES);
            if (!w_pick_ok && !r_busy_core[w_cand[IDXW-1:0]]) begin
                w_pick_ok = 1'b1;
                w_pick    = w_cand[IDXW-1:0];
            end
        end

        // a hit aborts everything, so nothing new is handed out that cycle
        w_dispatch = (r_state == S_RUN) && !w_hit && w_pick_ok;
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_next_state = S_RUN;
            end
            S_RUN: begin
                if (w_hit)
                    w_next_state = S_SOLVED;
                else if (w_dispatch && (r_next_key == LAST_KEY))
                    w_next_state = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_hit)
                    w_next_state = S_SOLVED;
                else if (r_busy_core == '0)
                    w_next_state = S_EXHAUSTED;
            end
            S_SOLVED, S_EXHAUSTED: begin
                if (start) w_next_state = S_RUN;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_busy_core   <= '0;
            r_last        <= '0;
            r_next_key    <= '0;
            r_core_start  <= '0;
            r_core_key    <= '0;
            r_abort_pulse <= 1'b0;
            r_found_key   <= '0;
            r_found_core  <= '0;
            r_keys_done   <= '0;
        end else begin
            r_core_start  <= '0;
            r_abort_pulse <= 1'b0;
            if (w_restart) begin
                // the accepted start already issues key 0 to core 0 so the
                // first dispatch pulse lands one cycle after start
                r_busy_core                <= NUM_CORES'(1);
                r_last                     <= '0;
                r_next_key                 <= KEY_BITS'(1);
                r_core_start               <= NUM_CORES'(1);
                r_core_key[KEY_BITS-1:0]   <= '0;
                r_keys_done                <= '0;
                r_found_key                <= '0;
                r_found_core               <= '0;
            end else begin
                r_keys_done <= r_keys_done + w_done_cnt;
                r_busy_core <= r_busy_core & ~w_done_ok;
                if (w_dispatch) begin
                    r_busy_core[w_pick]                         <= 1'b1;
                    r_core_start[w_pick]                        <= 1'b1;
                    r_core_key[w_pick*KEY_BITS +: KEY_BITS]     <= r_next_key;
                    r_last                                      <= w_pick;
                    // saturate: the last key moves us to DRAIN instead
                    if (r_next_key != LAST_KEY) r_next_key <= r_next_key + 1'b1;
                end
                if (w_hit) begin
                    r_found_key   <= r_core_key[w_hit_idx*KEY_BITS +: KEY_BITS];
                    r_found_core  <= 3'(w_hit_idx);
                    r_abort_pulse <= 1'b1;
                    r_busy_core   <= '0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // restart abort is combinational so it coincides with the start cycle
    assign core_abort = r_abort_pulse |
                        (start && ((r_state == S_SOLVED) || (r_state == S_EXHAUSTED)));
    assign core_start = r_core_start;
    assign core_key   = r_core_key;
    assign busy       = w_active;
    assign solved     = (r_state == S_SOLVED);
    assign exhausted  = (r_state == S_EXHAUSTED);
    assign found_key  = r_found_key;
    assign found_core = r_found_core;
    assign keys_done  = r_keys_done;

endmodule

// File: tb/tb_rc4_key_scheduler.sv
module tb_rc4_key_scheduler;

    localparam int NC = 4;
    localparam int KB = 6;
    localparam int NKEYS = 1 << KB;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [NC-1:0]     core_done;
    logic [NC-1:0]     core_valid;
    logic [NC-1:0]     core_start;
    logic [NC*KB-1:0]  core_key;
    logic              core_abort;
    logic              busy;
    logic              solved;
    logic              exhausted;
    logic [KB-1:0]     found_key;
    logic [2:0]        found_core;
    logic [KB:0]       keys_done;

    int checks = 0;
    int errors = 0;

    rc4_key_scheduler #(.NUM_CORES(NC), .KEY_BITS(KB)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .core_done(core_done), .core_valid(core_valid),
        .core_start(core_start), .core_key(core_key), .core_abort(core_abort),
        .busy(busy), .solved(solved), .exhausted(exhausted),
        .found_key(found_key), .found_core(found_core), .keys_done(keys_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int key_of(input int i);
        logic [NC*KB-1:0] v;
        v = core_key;
        return int'(v[i*KB +: KB]);
    endfunction

    // Behavioural model: cores answer after a random latency; the scheduler
    // must hand out keys 0,1,2.. in order, only to cores that are free, and
    // finish with the right verdict and completion count.
    task automatic run_search(input string tag, input int target, input int lo,
                              input int hi, input bit exp_solved, input int exp_core);
        int pend [NC];
        int pkey [NC];
        int last_done [NC];
        int next_exp, dones, viol, aborts, hit_core, cyc;
        bit fin;
        logic [NC-1:0] cd, cv;
        next_exp = 0; dones = 0; viol = 0; aborts = 0; hit_core = -1; cyc = 0; fin = 0;
        for (int i = 0; i < NC; i++) begin
            pend[i] = -1; pkey[i] = -1; last_done[i] = -100;
        end
        start = 1'b1; core_done = '0; core_valid = '0;
        step();
        start = 1'b0;
        while (!fin && cyc < 3000) begin
            cyc++;
            if (core_abort) begin
                aborts++;
                for (int i = 0; i < NC; i++) pend[i] = -1;
            end
            if (solved || exhausted) begin
                fin = 1;
            end else begin
                cd = '0; cv = '0;
                for (int i = 0; i < NC; i++) begin
                    if (pend[i] > 0) begin
                        pend[i]--;
                        if (pend[i] == 0) begin
                            cd[i] = 1'b1;
                            cv[i] = (pkey[i] == target);
                            pend[i] = -1;
                            last_done[i] = cyc;
                            dones++;
                        end
                    end
                end
                if ($countones(core_start) > 1) viol++;
                for (int i = 0; i < NC; i++) begin
                    if (core_start[i]) begin
                        if (pend[i] != -1 || cyc <= last_done[i]) viol++;
                        if (key_of(i) != next_exp) viol++;
                        pkey[i] = key_of(i);
                        if (pkey[i] == target) hit_core = i;
                        next_exp++;
                        pend[i] = $urandom_range(hi, lo);
                    end
                end
                core_done = cd; core_valid = cv;
                step();
                core_done = '0; core_valid = '0;
            end
        end
        chk({tag, " finished"}, int'(fin), 1);
        chk({tag, " protocol_violations"}, viol, 0);
        chk({tag, " solved"}, int'(solved), int'(exp_solved));
        chk({tag, " exhausted"}, int'(exhausted), int'(!exp_solved));
        chk({tag, " busy"}, int'(busy), 0);
        chk({tag, " keys_done"}, int'(keys_done), dones);
        chk({tag, " keys_in_range"}, int'(next_exp <= NKEYS), 1);
        if (exp_solved) begin
            chk({tag, " found_key"}, int'(found_key), target);
            chk({tag, " found_core"}, int'(found_core), hit_core);
            chk({tag, " abort_pulses"}, aborts, 1);
            if (exp_core >= 0) chk({tag, " found_core_fixed"}, int'(found_core), exp_core);
        end else begin
            chk({tag, " keys_done_all"}, int'(keys_done), NKEYS);
            chk({tag, " keys_dispatched"}, next_exp, NKEYS);
            chk({tag, " abort_pulses"}, aborts, 0);
        end
    endtask

    typedef struct {
        string nm;
        int    target;
        int    lo;
        int    hi;
        bit    exp_solved;
        int    exp_core;
    } vec_t;

    vec_t tbl [6];

    initial begin
        tbl[0] = '{"hit6_core2",  6,  4, 4, 1'b1,  2};
        tbl[1] = '{"exhaust_l1", -1,  1, 1, 1'b0, -1};
        tbl[2] = '{"hit_last",   63,  2, 5, 1'b1, -1};
        tbl[3] = '{"hit0",        0,  1, 3, 1'b1,  0};
        tbl[4] = '{"exhaust_rnd",-1,  3, 7, 1'b0, -1};
        tbl[5] = '{"hit40",      40,  1, 6, 1'b1, -1};

        reset_n = 1'b0; start = 1'b0; core_done = '0; core_valid = '0;
        #12;
        chk("rst core_start", int'(core_start), 0);
        chk("rst core_key", int'(core_key), 0);
        chk("rst core_abort", int'(core_abort), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst solved", int'(solved), 0);
        chk("rst exhausted", int'(exhausted), 0);
        chk("rst found_key", int'(found_key), 0);
        chk("rst found_core", int'(found_core), 0);
        chk("rst keys_done", int'(keys_done), 0);
        #1 reset_n = 1'b1;
        step();

        // dispatch order with no completions
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < NC; k++) begin
            chk($sformatf("order start c%0d", k), int'(core_start), 1 << k);
            chk($sformatf("order key c%0d", k), key_of(k), k);
            step();
        end
        for (int k = 0; k < 3; k++) begin
            chk("order no_fifth", int'(core_start), 0);
            step();
        end
        // done then redispatch
        core_done = 4'b0001;
        step();
        core_done = '0;
        chk("redisp not_early", int'(core_start), 0);
        step();
        chk("redisp start", int'(core_start), 1);
        chk("redisp key", key_of(0), 4);
        chk("redisp keys_done", int'(keys_done), 1);

        // asynchronous reset between edges
        chk("pre_rst busy", int'(busy), 1);
        #3 reset_n = 1'b0;
        #1;
        chk("arst busy", int'(busy), 0);
        chk("arst core_key", int'(core_key), 0);
        chk("arst core_start", int'(core_start), 0);
        chk("arst keys_done", int'(keys_done), 0);
        #2 reset_n = 1'b1;
        step();
        start = 1'b1;
        step();
        // start while running must be ignored
        chk("arst restart start", int'(core_start), 1);
        chk("arst restart key", key_of(0), 0);
        step();
        start = 1'b0;
        chk("ign_start core1", int'(core_start), 2);
        chk("ign_start key1", key_of(1), 1);
        step();
        step();
        step();
        // simultaneous valid from cores 1 and 3
        core_done = 4'b1010; core_valid = 4'b1010;
        step();
        core_done = '0; core_valid = '0;
        chk("simul solved", int'(solved), 1);
        chk("simul found_core", int'(found_core), 1);
        chk("simul found_key", int'(found_key), 1);
        chk("simul abort", int'(core_abort), 1);
        chk("simul busy", int'(busy), 0);
        chk("simul keys_done", int'(keys_done), 2);
        step();
        chk("simul abort_drop", int'(core_abort), 0);
        chk("simul sticky", int'(solved), 1);
        core_done = 4'b0001; core_valid = 4'b0001;
        step();
        core_done = '0; core_valid = '0;
        chk("solved ignores done", int'(keys_done), 2);
        chk("solved still", int'(solved), 1);
        start = 1'b1;
        #1;
        chk("restart abort", int'(core_abort), 1);
        step();
        start = 1'b0;
        chk("restart solved_clr", int'(solved), 0);
        chk("restart busy", int'(busy), 1);
        chk("restart start", int'(core_start), 1);
        chk("restart keys_done", int'(keys_done), 0);
        // completion from an idle core is ignored
        core_done = 4'b0100; core_valid = 4'b0100;
        step();
        core_done = '0; core_valid = '0;
        chk("idle_done solved", int'(solved), 0);
        chk("idle_done keys_done", int'(keys_done), 0);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();

        for (int t = 0; t < 6; t++)
            run_search(tbl[t].nm, tbl[t].target, tbl[t].lo, tbl[t].hi,
                       tbl[t].exp_solved, tbl[t].exp_core);

        for (int r = 0; r < 6; r++) begin
            int tgt, lo, hi;
            tgt = ($urandom_range(4, 0) == 0) ? -1 : int'($urandom_range(NKEYS-1, 0));
            lo  = $urandom_range(3, 1);
            hi  = lo + $urandom_range(5, 0);
            run_search($sformatf("rnd%0d", r), tgt, lo, hi, tgt >= 0, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
